// File: rtl/apb_trig_pkg.sv
// Shared constants for the APB trig slave: register offsets, Q2.14 values,
// bus-state encoding and the eight-entry sine table used by the compute core.
package apb_trig_pkg;

    localparam logic [4:0] ADDR_CTRL   = 5'h00;
    localparam logic [4:0] ADDR_SIN    = 5'h04;
    localparam logic [4:0] ADDR_COS    = 5'h08;
    localparam logic [4:0] ADDR_STATUS = 5'h0C;
    localparam logic [4:0] ADDR_TAN    = 5'h10;

    localparam logic [15:0] Q_H       = 16'h2D41;
    localparam logic [15:0] Q_ONE     = 16'h4000;
    localparam logic [15:0] Q_NEG_H   = 16'hD2BF;
    localparam logic [15:0] Q_NEG_ONE = 16'hC000;

    // Entry k is sin(k * 45 deg); entry 7 sits leftmost in the packed literal.
    localparam logic [7:0][15:0] SIN_TABLE = {
        Q_NEG_H, Q_NEG_ONE, Q_NEG_H, 16'h0000,
        Q_H,     Q_ONE,     Q_H,     16'h0000
    };

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_SETUP,
        BUS_ACCESS
    } bus_state_t;

    function automatic logic [31:0] sin_q(input logic [2:0] n);
        logic [15:0] v;
        v = SIN_TABLE[n];
        return {{16{v[15]}}, v};
    endfunction

    // The Q2.14 value occupies bits [15:0] only; bit16 flags the 90 deg pole.
    function automatic logic [31:0] tan_q(input logic [1:0] n);
        logic [31:0] v;
        case (n)
            2'd0:    v = 32'h0000_0000;
            2'd1:    v = {16'h0000, Q_ONE};
            2'd2:    v = {15'h0000, 1'b1, 16'h7FFF};
            default: v = {16'h0000, Q_NEG_ONE};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/apb_trig_core.sv
// Compute core: latches the angle index, counts LATENCY cycles, then publishes
// SIN/COS (and TAN when APB_TRIG_TAN_EN is defined) with BUSY/DONE status.
module apb_trig_core
    import apb_trig_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        start,
    input  logic [2:0]  start_n,
    input  logic        done_clr,
    output logic [2:0]  n,
    output logic        busy,
    output logic        done,
    output logic [31:0] sin_val,
`ifdef APB_TRIG_TAN_EN
    output logic [31:0] tan_val,
`endif
    output logic [31:0] cos_val
);

    logic [3:0] cnt;
    logic [2:0] res_n;
    logic       finish;

    assign finish = busy && (cnt == 4'd1);

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            n     <= 3'd0;
            busy  <= 1'b0;
            cnt   <= 4'd0;
            res_n <= 3'd0;
        end else if (start) begin
            n    <= start_n;
            busy <= 1'b1;
            cnt  <= 4'(LATENCY);
        end else if (busy) begin
            cnt <= cnt - 4'd1;
            if (finish) begin
                busy  <= 1'b0;
                res_n <= n;
            end
        end
    end

    // A completing compute outranks a same-cycle W1C of DONE.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET)
            done <= 1'b0;
        else if (start)
            done <= 1'b0;
        else if (finish)
            done <= 1'b1;
        else if (done_clr)
            done <= 1'b0;
    end

    // Results are a pure function of the last completed index, so the reset
    // value res_n=0 yields SIN=0 and COS=1.0 directly.
    assign sin_val = sin_q(res_n);
    assign cos_val = sin_q(res_n + 3'd2);
`ifdef APB_TRIG_TAN_EN
    assign tan_val = tan_q(res_n[1:0]);
`endif

endmodule

// File: rtl/apb_trig_slave.sv
// APB slave front end: bus FSM, address decode, wait-state and error logic
// around apb_trig_core. Defining APB_TRIG_TAN_EN maps the TAN register at 0x10.
module apb_trig_slave
    import apb_trig_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 32
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              IRQ
);

    bus_state_t  state, state_next, phase;
    logic [4:0]  addr;
    logic        is_ctrl, is_sin, is_cos, is_status, is_tan, is_result;
    logic        mapped, err, stall, accept, start, done_clr;
    logic [2:0]  n;
    logic        busy, done;
    logic [31:0] sin_val, cos_val, tan_val, rdata;
    logic        unused_bits;

    assign addr        = PADDR[4:0];
    assign unused_bits = ^{PADDR[ADDR_W-1:5], PWDATA[31:3]};

    assign is_ctrl   = (addr == ADDR_CTRL);
    assign is_sin    = (addr == ADDR_SIN);
    assign is_cos    = (addr == ADDR_COS);
    assign is_status = (addr == ADDR_STATUS);
`ifdef APB_TRIG_TAN_EN
    assign is_tan    = (addr == ADDR_TAN);
`else
    assign is_tan    = 1'b0;
    assign tan_val   = 32'h0;
`endif
    assign is_result = is_sin || is_cos || is_tan;
    assign mapped    = is_ctrl || is_status || is_result;
    assign err       = !mapped || (PWRITE && is_result);
    assign stall     = busy && ((PWRITE && is_ctrl) || (!PWRITE && is_result));

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET)
            state <= BUS_IDLE;
        else
            state <= state_next;
    end

    // state holds the phase of the previous cycle; phase is the current one,
    // which lets a zero-wait transfer finish in its first access cycle.
    always_comb begin
        phase      = BUS_IDLE;
        PREADY     = 1'b0;
        state_next = BUS_IDLE;
        if (PSEL && !PENABLE)
            phase = BUS_SETUP;
        else if (PSEL && PENABLE && (state != BUS_IDLE))
            phase = BUS_ACCESS;
        PREADY     = (phase == BUS_ACCESS) && !stall;
        state_next = PREADY ? BUS_IDLE : phase;
    end

    assign PSLVERR  = PREADY && err;
    assign accept   = PREADY && !err;
    assign start    = accept && PWRITE && is_ctrl;
    assign done_clr = accept && PWRITE && is_status && PWDATA[1];

    always_comb begin
        rdata = 32'h0;
        if (is_ctrl)
            rdata = {29'h0, n};
        else if (is_sin)
            rdata = sin_val;
        else if (is_cos)
            rdata = cos_val;
        else if (is_status)
            rdata = {30'h0, done, busy};
        else if (is_tan)
            rdata = tan_val;
    end

    assign PRDATA = (accept && !PWRITE) ? rdata : 32'h0;
    assign IRQ    = done;

    apb_trig_core #(
        .LATENCY (LATENCY)
    ) u_core (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .start    (start),
        .start_n  (PWDATA[2:0]),
        .done_clr (done_clr),
        .n        (n),
        .busy     (busy),
        .done     (done),
        .sin_val  (sin_val),
`ifdef APB_TRIG_TAN_EN
        .tan_val  (tan_val),
`endif
        .cos_val  (cos_val)
    );

endmodule

// File: tb/tb_apb_trig_slave.sv
// Self-checking bench for apb_trig_slave: directed APB sequences plus a
// randomized angle sweep compared against an arithmetic trig model.
module tb_apb_trig_slave;

    localparam int LAT      = 4;
    localparam int MAX_WAIT = 200;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_SIN    = 32'h04;
    localparam logic [31:0] A_COS    = 32'h08;
    localparam logic [31:0] A_STATUS = 32'h0C;
    localparam logic [31:0] A_TAN    = 32'h10;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        IRQ;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 PCLK = ~PCLK;

    apb_trig_slave #(
        .LATENCY (LAT),
        .ADDR_W  (32)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .IRQ     (IRQ)
    );

    // Reference: angle n*45 deg, magnitude 0 / sqrt(2)/2 / 1 in Q2.14.
    function automatic logic [31:0] model_sin(input int n);
        int k, mag, v;
        k   = n % 8;
        mag = (k % 4 == 0) ? 0 : ((k % 2 == 1) ? 'h2D41 : 'h4000);
        v   = (k >= 4) ? -mag : mag;
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_cos(input int n);
        return model_sin(n + 2);
    endfunction

    function automatic logic [31:0] model_tan(input int n);
        case (n % 4)
            0:       return 32'h0000_0000;
            1:       return 32'h0000_4000;
            2:       return 32'h0001_7FFF;
            default: return 32'h0000_C000;
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic sync_posedge();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge PCLK);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the completing edge.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int waits);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        waits = 0;
        @(negedge PCLK);
        while (PREADY !== 1'b1 && waits < MAX_WAIT) begin
            waits++;
            @(negedge PCLK);
        end
        rdata = PRDATA;
        err   = PSLVERR;
        total++;
        assert (PREADY === 1'b1) passed++;
        else begin
            failed++;
            $error("[TB] FAIL xfer_timeout: PREADY %b after %0d waits, expected 1", PREADY, waits);
        end
        @(posedge PCLK);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        er;
        int          w;
        apb_xfer(1'b0, addr, 32'h0, rd, er, w);
        check_output(tag, rd, exp);
        check_output({tag, "_err"}, {31'h0, er}, 32'h0);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        @(negedge PCLK);
        while (IRQ !== 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge PCLK);
        end
        sync_posedge();
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          w, cyc, n;
        logic [31:0] hi;

        PRESET  = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 32'h0;
        PWDATA  = 32'h0;

        #1;
        check_output("rst_pready",  {31'h0, PREADY},  32'h0);
        check_output("rst_pslverr", {31'h0, PSLVERR}, 32'h0);
        check_output("rst_prdata",  PRDATA,           32'h0);
        check_output("rst_irq",     {31'h0, IRQ},     32'h0);
        repeat (3) @(negedge PCLK);
        PRESET = 1'b1;
        sync_posedge();

        read_check("rst_ctrl",   A_CTRL,   32'h0);
        read_check("rst_sin",    A_SIN,    32'h0);
        read_check("rst_cos",    A_COS,    32'h0000_4000);
        read_check("rst_status", A_STATUS, 32'h0);

        // CTRL=1: IRQ after exactly LAT cycles, SIN=COS=H
        apb_xfer(1'b1, A_CTRL, 32'h1, rd, er, w);
        check_output("ctrl1_waits", 32'(w), 32'h0);
        wait_done(cyc);
        check_output("ctrl1_irq_cycles", 32'(cyc), 32'(LAT));
        read_check("ctrl1_sin",    A_SIN,    32'h0000_2D41);
        read_check("ctrl1_cos",    A_COS,    32'h0000_2D41);
        read_check("ctrl1_status", A_STATUS, 32'h2);
        apb_xfer(1'b1, A_STATUS, 32'h1, rd, er, w);
        check_output("w1c_bit0_irq", {31'h0, IRQ}, 32'h1);
        apb_xfer(1'b1, A_STATUS, 32'h2, rd, er, w);
        check_output("w1c_irq", {31'h0, IRQ}, 32'h0);

        // CTRL=6 then immediate SIN read: stalled through the compute
        apb_xfer(1'b1, A_CTRL, 32'h6, rd, er, w);
        apb_xfer(1'b0, A_SIN, 32'h0, rd, er, w);
        check_output("sin_stall_cycles", 32'(w + 1), 32'(LAT));
        check_output("sin_stall_data", rd, 32'hFFFF_C000);

        // Back-to-back CTRL writes 2 then 3
        apb_xfer(1'b1, A_CTRL, 32'h2, rd, er, w);
        apb_xfer(1'b1, A_CTRL, 32'h3, rd, er, w);
        check_output("b2b_waits", 32'(w), 32'(LAT - 1));
        wait_done(cyc);
        check_output("b2b_irq_cycles", 32'(cyc), 32'(LAT));
        read_check("b2b_cos",  A_COS,  32'hFFFF_D2BF);
        read_check("b2b_ctrl", A_CTRL, 32'h3);

        // Error responses
        apb_xfer(1'b0, 32'h14, 32'h0, rd, er, w);
        check_output("unmapped_err",   {31'h0, er}, 32'h1);
        check_output("unmapped_waits", 32'(w), 32'h0);
        check_output("unmapped_data",  rd, 32'h0);
        apb_xfer(1'b1, A_SIN, $urandom, rd, er, w);
        check_output("wr_sin_err",   {31'h0, er}, 32'h1);
        check_output("wr_sin_waits", 32'(w), 32'h0);
        apb_xfer(1'b1, A_COS, 32'h5, rd, er, w);
        check_output("wr_cos_err", {31'h0, er}, 32'h1);
        apb_xfer(1'b0, 32'h01, 32'h0, rd, er, w);
        check_output("misaligned_err", {31'h0, er}, 32'h1);
        read_check("err_sin_kept",  A_SIN,  model_sin(3));
        read_check("err_ctrl_kept", A_CTRL, 32'h3);
        @(negedge PCLK);
        check_output("prdata_idle", PRDATA, 32'h0);
        sync_posedge();

`ifdef APB_TRIG_TAN_EN
        apb_xfer(1'b1, A_CTRL, 32'h2, rd, er, w);
        wait_done(cyc);
        read_check("tan_n2", A_TAN, 32'h0001_7FFF);
`else
        apb_xfer(1'b0, A_TAN, 32'h0, rd, er, w);
        check_output("tan_unmapped_err",  {31'h0, er}, 32'h1);
        check_output("tan_unmapped_data", rd, 32'h0);
`endif

        // W1C landing on the completion edge: DONE must stay set
        apb_xfer(1'b1, A_CTRL, 32'h5, rd, er, w);
        idle(LAT - 2);
        apb_xfer(1'b1, A_STATUS, 32'h2, rd, er, w);
        @(negedge PCLK);
        check_output("race_irq", {31'h0, IRQ}, 32'h1);
        sync_posedge();
        read_check("race_status", A_STATUS, 32'h2);
        apb_xfer(1'b1, A_STATUS, 32'h2, rd, er, w);

        // Abort a stalled CTRL write by dropping PSEL
        apb_xfer(1'b1, A_CTRL, 32'h7, rd, er, w);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = A_CTRL;
        PWDATA  = 32'h4;
        sync_posedge();
        PENABLE = 1'b1;
        @(negedge PCLK);
        check_output("abort_stalled", {31'h0, PREADY}, 32'h0);
        sync_posedge();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        wait_done(cyc);
        check_output("abort_done_cycles", 32'(cyc), 32'(LAT - 2));
        read_check("abort_ctrl",   A_CTRL,   32'h7);
        read_check("abort_status", A_STATUS, 32'h2);
        read_check("abort_sin",    A_SIN,    model_sin(7));

        // Randomized angles with junk in PWDATA[31:3]
        for (int i = 0; i < 8; i++) begin
            n  = int'($urandom_range(0, 7));
            hi = $urandom;
            apb_xfer(1'b1, A_CTRL, {hi[31:3], 3'(n)}, rd, er, w);
            if ($urandom_range(0, 1) == 1) begin
                apb_xfer(1'b0, A_COS, 32'h0, rd, er, w);
                check_output("rnd_cos_stall", 32'(w), 32'(LAT - 1));
                check_output("rnd_cos_stalled_data", rd, model_cos(n));
            end else begin
                wait_done(cyc);
                check_output("rnd_irq_cycles", 32'(cyc), 32'(LAT));
                read_check("rnd_cos", A_COS, model_cos(n));
            end
            read_check("rnd_sin",    A_SIN,    model_sin(n));
            read_check("rnd_ctrl",   A_CTRL,   32'(n));
            read_check("rnd_status", A_STATUS, 32'h2);
`ifdef APB_TRIG_TAN_EN
            read_check("rnd_tan", A_TAN, model_tan(n));
`endif
            apb_xfer(1'b1, A_STATUS, 32'h2, rd, er, w);
        end

        // Reset in the middle of a compute
        apb_xfer(1'b1, A_CTRL, 32'h1, rd, er, w);
        idle(2);
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        check_output("midrst_pready",  {31'h0, PREADY},  32'h0);
        check_output("midrst_pslverr", {31'h0, PSLVERR}, 32'h0);
        check_output("midrst_prdata",  PRDATA,           32'h0);
        check_output("midrst_irq",     {31'h0, IRQ},     32'h0);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b1;
        sync_posedge();
        idle(LAT + 2);
        check_output("midrst_no_done", {31'h0, IRQ}, 32'h0);
        read_check("midrst_status", A_STATUS, 32'h0);
        read_check("midrst_ctrl",   A_CTRL,   32'h0);
        read_check("midrst_sin",    A_SIN,    32'h0);
        read_check("midrst_cos",    A_COS,    32'h0000_4000);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
